// File: rtl/msrv32_pkg.sv
// Shared types and codes for the RV32 data-memory path.
package msrv32_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10,
        ST_DONE = 2'b11
    } dmem_state_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // Size code 11 behaves as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return addr_lo[0];
            default:   return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/msrv32_store_align.sv
// Store lane replication and byte-strobe generation for the data bus.
module msrv32_store_align
    import msrv32_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [31:0] hwdata,
    output logic [3:0]  mask
);

    always_comb begin
        hwdata = wdata;
        mask   = 4'b1111;
        case (size)
            SIZE_BYTE: begin
                hwdata = {4{wdata[7:0]}};
                mask   = 4'b0001 << addr_lo;
            end
            SIZE_HALF: begin
                hwdata = {2{wdata[15:0]}};
                mask   = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/msrv32_dmem_ctrl.sv
// Data-memory transaction controller: one load/store at a time on an
// AHB-Lite-style bus, with wait-state absorption and a data-phase timeout.
//
// state | meaning
// IDLE  | ready for a request; misaligned requests skip straight to DONE
// ADDR  | NONSEQ address phase, held until hready
// DATA  | data phase, counting wait cycles against WAIT_LIMIT
// DONE  | one-cycle completion pulse to the load unit
module msrv32_dmem_ctrl #(
    parameter int WAIT_LIMIT = 16
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic        req_store_in,
    input  logic [31:0] req_addr_in,
    input  logic [1:0]  req_size_in,
    input  logic        req_unsigned_in,
    input  logic [31:0] req_wdata_in,
    output logic [31:0] haddr_out,
    output logic [1:0]  htrans_out,
    output logic        hwrite_out,
    output logic [31:0] hwdata_out,
    output logic [3:0]  wr_mask_out,
    input  logic [31:0] hrdata_in,
    input  logic        hready_in,
    input  logic        hresp_in,
    output logic [31:0] lu_data_out,
    output logic [1:0]  lu_load_size_out,
    output logic        lu_load_unsigned_out,
    output logic [1:0]  lu_iadder_1_to_0_out,
    output logic        lu_ahb_resp_out,
    output logic        done_valid_out,
    output logic        misaligned_out,
    output logic        stall_out
);
    import msrv32_pkg::*;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

    dmem_state_e state;
    logic        store_q;
    logic [1:0]  addr_lo_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] wdata_q;
    logic [7:0]  wait_cnt;
    logic [3:0]  lane_mask;

    msrv32_store_align u_align (
        .size    (size_q),
        .addr_lo (addr_lo_q),
        .wdata   (wdata_q),
        .hwdata  (hwdata_out),
        .mask    (lane_mask)
    );

    assign wr_mask_out = (state == ST_ADDR && store_q) ? lane_mask : 4'b0000;
    assign stall_out   = (state == ST_ADDR) || (state == ST_DATA) ||
                         (state == ST_IDLE && req_valid_in);

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state                <= ST_IDLE;
            req_ready_out        <= 1'b1;
            htrans_out           <= HTRANS_IDLE;
            hwrite_out           <= 1'b0;
            haddr_out            <= '0;
            done_valid_out       <= 1'b0;
            misaligned_out       <= 1'b0;
            wait_cnt             <= '0;
            store_q              <= 1'b0;
            addr_lo_q            <= '0;
            size_q               <= '0;
            unsigned_q           <= 1'b0;
            wdata_q              <= '0;
            lu_data_out          <= '0;
            lu_load_size_out     <= '0;
            lu_load_unsigned_out <= 1'b0;
            lu_iadder_1_to_0_out <= '0;
            lu_ahb_resp_out      <= 1'b0;
        end else begin
            done_valid_out <= 1'b0;
            misaligned_out <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid_in) begin
                        store_q       <= req_store_in;
                        addr_lo_q     <= req_addr_in[1:0];
                        size_q        <= req_size_in;
                        unsigned_q    <= req_unsigned_in;
                        wdata_q       <= req_wdata_in;
                        req_ready_out <= 1'b0;
                        if (is_misaligned(req_size_in, req_addr_in[1:0])) begin
                            state                <= ST_DONE;
                            done_valid_out       <= 1'b1;
                            misaligned_out       <= 1'b1;
                            lu_load_size_out     <= req_size_in;
                            lu_load_unsigned_out <= req_unsigned_in;
                            lu_iadder_1_to_0_out <= req_addr_in[1:0];
                        end else begin
                            state      <= ST_ADDR;
                            htrans_out <= HTRANS_NONSEQ;
                            hwrite_out <= req_store_in;
                            haddr_out  <= {req_addr_in[31:2], 2'b00};
                        end
                    end
                end
                ST_ADDR: begin
                    if (hready_in) begin
                        state      <= ST_DATA;
                        htrans_out <= HTRANS_IDLE;
                        hwrite_out <= 1'b0;
                        wait_cnt   <= '0;
                    end
                end
                ST_DATA: begin
                    // A timeout reports an error but leaves the previous read word intact.
                    if (hready_in || wait_cnt == WAIT_LAST) begin
                        state                <= ST_DONE;
                        done_valid_out       <= 1'b1;
                        lu_load_size_out     <= size_q;
                        lu_load_unsigned_out <= unsigned_q;
                        lu_iadder_1_to_0_out <= addr_lo_q;
                        if (hready_in) begin
                            lu_data_out     <= hrdata_in;
                            lu_ahb_resp_out <= hresp_in;
                        end else begin
                            lu_ahb_resp_out <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    state         <= ST_IDLE;
                    req_ready_out <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_msrv32_dmem_ctrl.sv
// Directed bench for msrv32_dmem_ctrl with hand-computed expectations.
module tb_msrv32_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] hwdata;
    logic [3:0]  wr_mask;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;
    logic [31:0] lu_data;
    logic [1:0]  lu_size;
    logic        lu_unsigned;
    logic [1:0]  lu_off;
    logic        lu_resp;
    logic        done_valid;
    logic        misaligned;
    logic        stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    msrv32_dmem_ctrl #(.WAIT_LIMIT(4)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .req_valid_in         (req_valid),
        .req_ready_out        (req_ready),
        .req_store_in         (req_store),
        .req_addr_in          (req_addr),
        .req_size_in          (req_size),
        .req_unsigned_in      (req_unsigned),
        .req_wdata_in         (req_wdata),
        .haddr_out            (haddr),
        .htrans_out           (htrans),
        .hwrite_out           (hwrite),
        .hwdata_out           (hwdata),
        .wr_mask_out          (wr_mask),
        .hrdata_in            (hrdata),
        .hready_in            (hready),
        .hresp_in             (hresp),
        .lu_data_out          (lu_data),
        .lu_load_size_out     (lu_size),
        .lu_load_unsigned_out (lu_unsigned),
        .lu_iadder_1_to_0_out (lu_off),
        .lu_ahb_resp_out      (lu_resp),
        .done_valid_out       (done_valid),
        .misaligned_out       (misaligned),
        .stall_out            (stall)
    );

    // Start of a cycle: just after the rising edge, where inputs are driven.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle sample point.
    task automatic smp();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        smp();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", req_ready); end
        checks++; if (htrans !== 2'b00) begin errors++; $display("FAIL rst_htrans got %h exp 0", htrans); end
        checks++; if ({haddr, hwdata} !== 64'd0) begin errors++; $display("FAIL rst_bus got %h %h exp 0 0", haddr, hwdata); end
        checks++; if ({wr_mask, hwrite, done_valid, misaligned, stall} !== 8'd0) begin errors++; $display("FAIL rst_ctl got %b exp 0", {wr_mask, hwrite, done_valid, misaligned, stall}); end
        checks++; if ({lu_data, lu_size, lu_unsigned, lu_off, lu_resp} !== 38'd0) begin errors++; $display("FAIL rst_lu got %h exp 0", {lu_data, lu_size, lu_unsigned, lu_off, lu_resp}); end
    endtask

    task automatic test_load_byte();
        cyc();
        req_valid = 1'b1; req_store = 1'b0; req_addr = 32'h0000_1003; req_size = 2'b00;
        req_unsigned = 1'b1; hrdata = 32'h80FF_0000; hready = 1'b1; hresp = 1'b0;
        smp();
        checks++; if ({req_ready, stall} !== 2'b11) begin errors++; $display("FAIL lbu_c0_ready_stall got %b exp 11", {req_ready, stall}); end
        cyc(); req_valid = 1'b0; smp();
        checks++; if (htrans !== 2'b10) begin errors++; $display("FAIL lbu_c1_htrans got %h exp 2", htrans); end
        checks++; if (haddr !== 32'h0000_1000) begin errors++; $display("FAIL lbu_c1_haddr got %h exp 00001000", haddr); end
        checks++; if ({hwrite, wr_mask, req_ready, stall} !== 7'b0000001) begin errors++; $display("FAIL lbu_c1_ctl got %b exp 0000001", {hwrite, wr_mask, req_ready, stall}); end
        cyc(); smp();
        checks++; if ({htrans, done_valid, stall} !== 4'b0001) begin errors++; $display("FAIL lbu_c2_data got %b exp 0001", {htrans, done_valid, stall}); end
        cyc(); smp();
        checks++; if ({done_valid, misaligned, stall} !== 3'b100) begin errors++; $display("FAIL lbu_c3_done got %b exp 100", {done_valid, misaligned, stall}); end
        checks++; if (lu_data !== 32'h80FF_0000) begin errors++; $display("FAIL lbu_lu_data got %h exp 80ff0000", lu_data); end
        checks++; if ({lu_off, lu_unsigned, lu_size, lu_resp} !== 6'b111000) begin errors++; $display("FAIL lbu_lu_attr got %b exp 111000", {lu_off, lu_unsigned, lu_size, lu_resp}); end
        cyc(); smp();
        checks++; if ({done_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL lbu_c4_idle got %b exp 01", {done_valid, req_ready}); end
    endtask

    task automatic test_store_half_waits();
        cyc();
        req_valid = 1'b1; req_store = 1'b1; req_addr = 32'h0000_2002; req_size = 2'b01;
        req_unsigned = 1'b0; req_wdata = 32'h0000_BEEF; hready = 1'b1;
        cyc(); req_valid = 1'b0; smp();
        checks++; if ({htrans, hwrite, wr_mask} !== 7'b1011100) begin errors++; $display("FAIL sh_addr_phase got %b exp 1011100", {htrans, hwrite, wr_mask}); end
        checks++; if (haddr !== 32'h0000_2000) begin errors++; $display("FAIL sh_haddr got %h exp 00002000", haddr); end
        cyc(); hready = 1'b0; smp();
        checks++; if (hwdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_hwdata got %h exp beefbeef", hwdata); end
        cyc(); smp();
        checks++; if ({done_valid, stall} !== 2'b01) begin errors++; $display("FAIL sh_wait2 got %b exp 01", {done_valid, stall}); end
        cyc(); hready = 1'b1; hrdata = 32'h1234_5678; smp();
        checks++; if (done_valid !== 1'b0) begin errors++; $display("FAIL sh_c4_done got %b exp 0", done_valid); end
        cyc(); smp();
        checks++; if ({done_valid, lu_resp, lu_off, lu_size} !== 6'b101001) begin errors++; $display("FAIL sh_c5_done got %b exp 101001", {done_valid, lu_resp, lu_off, lu_size}); end
        cyc(); smp();
    endtask

    task automatic test_misaligned();
        cyc();
        req_valid = 1'b1; req_store = 1'b0; req_addr = 32'h0000_3001; req_size = 2'b10; req_unsigned = 1'b0;
        smp();
        checks++; if ({htrans, stall} !== 3'b001) begin errors++; $display("FAIL mis_c0 got %b exp 001", {htrans, stall}); end
        cyc(); req_valid = 1'b0; smp();
        checks++; if ({done_valid, misaligned, htrans, stall} !== 5'b11000) begin errors++; $display("FAIL mis_c1_done got %b exp 11000", {done_valid, misaligned, htrans, stall}); end
        cyc(); smp();
        checks++; if ({done_valid, misaligned, htrans, req_ready} !== 5'b00001) begin errors++; $display("FAIL mis_c2_idle got %b exp 00001", {done_valid, misaligned, htrans, req_ready}); end
    endtask

    task automatic test_bus_error();
        cyc();
        req_valid = 1'b1; req_store = 1'b0; req_addr = 32'h0000_4000; req_size = 2'b10;
        hready = 1'b1; hresp = 1'b1; hrdata = 32'hDEAD_BEEF;
        cyc(); req_valid = 1'b0;
        cyc();
        cyc(); smp();
        checks++; if ({done_valid, lu_resp} !== 2'b11) begin errors++; $display("FAIL err_c3 got %b exp 11", {done_valid, lu_resp}); end
        checks++; if (lu_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL err_data got %h exp deadbeef", lu_data); end
        cyc(); hresp = 1'b0; smp();
    endtask

    task automatic test_timeout();
        cyc();
        req_valid = 1'b1; req_store = 1'b0; req_addr = 32'h0000_5000; req_size = 2'b10;
        hready = 1'b1; hresp = 1'b0; hrdata = 32'hCAFE_F00D;
        cyc(); req_valid = 1'b0;
        cyc(); hready = 1'b0;
        cyc(); cyc(); cyc(); smp();
        checks++; if ({done_valid, stall} !== 2'b01) begin errors++; $display("FAIL tmo_c5 got %b exp 01", {done_valid, stall}); end
        cyc(); smp();
        checks++; if ({done_valid, lu_resp, stall} !== 3'b110) begin errors++; $display("FAIL tmo_c6 got %b exp 110", {done_valid, lu_resp, stall}); end
        checks++; if (lu_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL tmo_data_kept got %h exp deadbeef", lu_data); end
        cyc(); hready = 1'b1; smp();
    endtask

    task automatic test_back_to_back();
        cyc();
        req_valid = 1'b1; req_store = 1'b0; req_addr = 32'h0000_6000; req_size = 2'b10; hrdata = 32'h1122_3344;
        cyc();
        req_store = 1'b1; req_addr = 32'h0000_7006; req_size = 2'b00; req_wdata = 32'h0000_003C;
        smp();
        checks++; if ({haddr, hwrite, req_ready} !== {32'h0000_6000, 2'b00}) begin errors++; $display("FAIL b2b_ignored got %h %b exp 00006000 00", haddr, {hwrite, req_ready}); end
        cyc(); cyc(); smp();
        checks++; if ({done_valid, req_ready, stall} !== 3'b100) begin errors++; $display("FAIL b2b_done1 got %b exp 100", {done_valid, req_ready, stall}); end
        checks++; if (lu_data !== 32'h1122_3344) begin errors++; $display("FAIL b2b_data got %h exp 11223344", lu_data); end
        cyc(); smp();
        checks++; if ({req_ready, stall} !== 2'b11) begin errors++; $display("FAIL b2b_accept got %b exp 11", {req_ready, stall}); end
        cyc(); req_valid = 1'b0; smp();
        checks++; if ({htrans, hwrite, wr_mask} !== 7'b1010100) begin errors++; $display("FAIL b2b_sb_addr got %b exp 1010100", {htrans, hwrite, wr_mask}); end
        checks++; if (haddr !== 32'h0000_7004) begin errors++; $display("FAIL b2b_haddr got %h exp 00007004", haddr); end
        cyc(); smp();
        checks++; if (hwdata !== 32'h3C3C_3C3C) begin errors++; $display("FAIL b2b_hwdata got %h exp 3c3c3c3c", hwdata); end
        cyc(); smp();
        checks++; if (done_valid !== 1'b1) begin errors++; $display("FAIL b2b_done2 got %b exp 1", done_valid); end
        cyc(); smp();
    endtask

    task automatic test_reset_mid_data();
        cyc();
        req_valid = 1'b1; req_store = 1'b0; req_addr = 32'h0000_8000; req_size = 2'b10; hready = 1'b1;
        cyc(); req_valid = 1'b0;
        cyc(); hready = 1'b0;
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0; hready = 1'b1; smp();
        checks++; if ({req_ready, htrans, done_valid, stall} !== 5'b10000) begin errors++; $display("FAIL rmid_idle got %b exp 10000", {req_ready, htrans, done_valid, stall}); end
        checks++; if ({lu_data, lu_resp} !== 33'd0) begin errors++; $display("FAIL rmid_lu got %h exp 0", {lu_data, lu_resp}); end
        cyc(); smp();
        checks++; if (done_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_done got %b exp 0", done_valid); end
        cyc();
        req_valid = 1'b1; req_store = 1'b1; req_addr = 32'h0000_0010; req_size = 2'b00; req_wdata = 32'h0000_00A5;
        cyc(); req_valid = 1'b0; smp();
        checks++; if ({htrans, wr_mask} !== 6'b100001) begin errors++; $display("FAIL rmid_sb_mask got %b exp 100001", {htrans, wr_mask}); end
        checks++; if (haddr !== 32'h0000_0010) begin errors++; $display("FAIL rmid_haddr got %h exp 00000010", haddr); end
        cyc(); smp();
        checks++; if (hwdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL rmid_hwdata got %h exp a5a5a5a5", hwdata); end
        cyc(); smp();
        checks++; if (done_valid !== 1'b1) begin errors++; $display("FAIL rmid_sb_done got %b exp 1", done_valid); end
        cyc(); smp();
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_addr = '0; req_size = '0;
        req_unsigned = 1'b0; req_wdata = '0; hrdata = '0; hready = 1'b1; hresp = 1'b0;
        test_reset();
        test_load_byte();
        test_store_half_waits();
        test_misaligned();
        test_bus_error();
        test_timeout();
        test_back_to_back();
        test_reset_mid_data();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
